// File: rtl/lut_eval_pkg.sv
// Shared types and constants for the programmable truth-table evaluator.
package lut_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Y = A&B | ~(A|C) with index {A,B,C}
   localparam logic [7:0] DEFAULT_TABLE_3 = 8'hC5;

   function automatic int popcount_w(input int n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/lut_eval_seq_table.sv
// Runtime-writable truth-table register with one bit-write port and one
// combinational read port.
module lut_table_reg
   import lut_eval_pkg::*;
#(
   parameter int                  N_IN          = 3,
   parameter logic [2**N_IN-1:0]  DEFAULT_TABLE = (2**N_IN)'(DEFAULT_TABLE_3)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [N_IN-1:0]   wr_addr,
   input  logic              wr_data,
   input  logic [N_IN-1:0]   rd_addr,
   output logic              rd_data
);

   logic [2**N_IN-1:0] table_q;
   logic [2**N_IN-1:0] table_d;

   always_comb begin
      table_d = table_q;
      if (wr_en) begin
         table_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         table_q <= DEFAULT_TABLE;
      end else begin
         table_q <= table_d;
      end
   end

   // Reads see the pre-write contents, so a same-cycle write/eval gets the old bit
   assign rd_data = table_q[rd_addr];

endmodule

// File: rtl/lut_eval_seq.sv
// Programmable N-input truth-table evaluator with a registered valid/ready
// eval stage and a self-sweep that counts the 1 minterms of the table.
module lut_eval_seq
   import lut_eval_pkg::*;
#(
   parameter int                  N_IN          = 3,
   parameter logic [2**N_IN-1:0]  DEFAULT_TABLE = (2**N_IN)'(DEFAULT_TABLE_3)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [N_IN-1:0]   cfg_addr,
   input  logic              cfg_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_data,
   input  logic              sweep_start,
   output logic              busy,
   output logic              sweep_done,
   output logic [N_IN:0]     sweep_count
);

   localparam int CW = popcount_w(N_IN);

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [CW-1:0]     acc_q, acc_d;
   logic [CW-1:0]     sweep_count_q, sweep_count_d;
   logic              out_valid_q, out_valid_d;
   logic              out_data_q, out_data_d;
   logic              busy_q, busy_d;
   logic              sweep_done_q, sweep_done_d;

   logic              accept;
   logic              tbl_we;
   logic [N_IN-1:0]   rd_addr;
   logic              rd_bit;

   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign tbl_we   = cfg_we && (state_q == IDLE);

   // Evals are only accepted in IDLE, so the sweep can own the read port otherwise
   assign rd_addr  = (state_q == SWEEP) ? idx_q : in_data;

   lut_table_reg #(
      .N_IN          (N_IN),
      .DEFAULT_TABLE (DEFAULT_TABLE)
   ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tbl_we),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_addr (rd_addr),
      .rd_data (rd_bit)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      acc_d         = acc_q;
      sweep_count_d = sweep_count_q;
      case (state_q)
         IDLE: begin
            if (sweep_start) begin
               state_d = SWEEP;
               idx_d   = '0;
               acc_d   = '0;
            end
         end
         SWEEP: begin
            acc_d = acc_q + CW'(rd_bit);
            idx_d = idx_q + N_IN'(1);
            if (idx_q == {N_IN{1'b1}}) begin
               state_d       = DONE;
               sweep_count_d = acc_d;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d       = (state_d == SWEEP);
      sweep_done_d = (state_d == DONE);
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = rd_bit;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         acc_q         <= '0;
         sweep_count_q <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 1'b0;
         busy_q        <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         acc_q         <= acc_d;
         sweep_count_q <= sweep_count_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         busy_q        <= busy_d;
         sweep_done_q  <= sweep_done_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign sweep_done  = sweep_done_q;
   assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_lut_eval_seq.sv
// Self-checking bench for lut_eval_seq: a 3-input instance against a bit-vector
// and queue reference model, plus a 4-input all-ones instance for sweep width.
module tb_lut_eval_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we, cfg_data, in_valid, in_ready, out_valid, out_ready, out_data;
   logic       sweep_start, busy, sweep_done;
   logic [2:0] cfg_addr, in_data;
   logic [3:0] sweep_count;

   logic       w_cfg_we, w_cfg_data, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_data;
   logic       w_sweep_start, w_busy, w_sweep_done;
   logic [3:0] w_cfg_addr, w_in_data;
   logic [4:0] w_sweep_count;

   int         errors = 0;
   int         checks = 0;
   logic [7:0]  m_table;
   logic [15:0] m_table_w;

   always #5 clk = ~clk;

   lut_eval_seq #(.N_IN(3)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sweep_start(sweep_start), .busy(busy), .sweep_done(sweep_done), .sweep_count(sweep_count)
   );

   lut_eval_seq #(.N_IN(4), .DEFAULT_TABLE(16'hFFFF)) dut_w (
      .clk(clk), .rst_n(rst_n), .cfg_we(w_cfg_we), .cfg_addr(w_cfg_addr), .cfg_data(w_cfg_data),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .sweep_start(w_sweep_start), .busy(w_busy), .sweep_done(w_sweep_done), .sweep_count(w_sweep_count)
   );

   // Inputs change on the falling edge; the DUT samples them on the next rising edge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      m_table   = 8'hC5;
      m_table_w = 16'hFFFF;
      rst_n = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++; if (out_data !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_data got %b expected 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      checks++; if (sweep_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_sweep_done got %b expected 0", sweep_done); end
      checks++; if (sweep_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_sweep_count got %0d expected 0", sweep_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
   endtask

   task automatic test_eval_default();
      logic [2:0] v;
      logic       a, b, c, y;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         a = v[2]; b = v[1]; c = v[0];
         y = (a & b) | ~(a | c);
         in_valid = 1'b1;
         in_data  = v;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL eval_in_ready idx %0d got %b expected 1", i, in_ready); end
         tick();
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== y) begin
            errors++; $display("[TB] FAIL eval_default idx %0d got valid=%b data=%b expected valid=1 data=%b", i, out_valid, out_data, y);
         end
      end
      in_valid = 1'b0;
      tick();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL eval_drain got %b expected 0", out_valid); end
   endtask

   task automatic test_sweep(input int exp_count);
      sweep_start = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         in_valid = 1'b1;
         in_data  = 3'($urandom_range(0, 7));
         #1;
         checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || sweep_done !== 1'b0) begin
            errors++; $display("[TB] FAIL sweep_cycle %0d got busy=%b in_ready=%b done=%b expected 1/0/0", c, busy, in_ready, sweep_done);
         end
         tick();
      end
      in_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || sweep_done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL sweep_done_cycle got busy=%b done=%b in_ready=%b out_valid=%b expected 0/1/0/0", busy, sweep_done, in_ready, out_valid);
      end
      checks++; if (sweep_count !== 4'(exp_count)) begin errors++; $display("[TB] FAIL sweep_count got %0d expected %0d", sweep_count, exp_count); end
      tick();
      #1;
      checks++; if (sweep_done !== 1'b0 || in_ready !== 1'b1 || sweep_count !== 4'(exp_count)) begin
         errors++; $display("[TB] FAIL sweep_after got done=%b in_ready=%b count=%0d expected 0/1/%0d", sweep_done, in_ready, sweep_count, exp_count);
      end
   endtask

   task automatic test_write_collision();
      logic old_bit;
      out_ready = 1'b1;
      old_bit   = m_table[1];
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 1'b1;
      in_valid = 1'b1; in_data = 3'd1;
      tick();
      m_table[1] = 1'b1;
      cfg_we = 1'b0;
      #1;
      checks++; if (out_data !== old_bit) begin errors++; $display("[TB] FAIL write_same_cycle got %b expected %b", out_data, old_bit); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_data !== m_table[1]) begin errors++; $display("[TB] FAIL write_next_cycle got %b expected %b", out_data, m_table[1]); end
      tick();
      test_sweep($countones(m_table));
   endtask

   task automatic test_backpressure();
      logic exp_q[$];
      logic accept_m;
      logic held;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 3'd2;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready got %b expected 1", in_ready); end
      tick();
      held = m_table[2];
      in_data = 3'd3;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_hold cycle %0d got valid=%b data=%b in_ready=%b expected 1/%b/0", c, out_valid, out_data, in_ready, held);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b expected 1", in_ready); end
      tick();
      exp_q.push_back(m_table[3]);
      for (int c = 0; c < 300; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 3'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         cfg_we    = ($urandom_range(0, 4) == 0);
         cfg_addr  = 3'($urandom_range(0, 7));
         cfg_data  = 1'($urandom_range(0, 1));
         #1;
         checks++; if (out_valid !== (exp_q.size() != 0)) begin
            errors++; $display("[TB] FAIL rand_out_valid cycle %0d got %b expected %b", c, out_valid, exp_q.size() != 0);
         end
         checks++; if (in_ready !== (exp_q.size() == 0 || out_ready)) begin
            errors++; $display("[TB] FAIL rand_in_ready cycle %0d got %b expected %b", c, in_ready, exp_q.size() == 0 || out_ready);
         end
         if (exp_q.size() != 0) begin
            checks++; if (out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_out_data cycle %0d got %b expected %b", c, out_data, exp_q[0]); end
         end
         accept_m = in_valid && (exp_q.size() == 0 || out_ready);
         if (exp_q.size() != 0 && out_ready) exp_q.pop_front();
         if (accept_m) exp_q.push_back(m_table[in_data]);
         if (cfg_we) m_table[cfg_addr] = cfg_data;
         tick();
      end
      in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      #1;
      if (exp_q.size() != 0) begin
         checks++; if (out_data !== exp_q[0]) begin errors++; $display("[TB] FAIL rand_final_data got %b expected %b", out_data, exp_q[0]); end
      end
      tick();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_drained got %b expected 0", out_valid); end
   endtask

   task automatic test_sweep_ignore();
      logic [2:0] a;
      logic [3:0] exp_count;
      a = 3'($urandom_range(0, 7));
      exp_count = 4'($countones(m_table));
      out_ready = 1'b1; in_valid = 1'b0;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         cfg_we      = (c == 3);
         sweep_start = (c == 3);
         cfg_addr    = a;
         cfg_data    = ~m_table[a];
         #1;
         checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy cycle %0d got %b expected 1", c, busy); end
         tick();
      end
      cfg_we = 1'b0; sweep_start = 1'b0;
      #1;
      checks++; if (sweep_done !== 1'b1 || sweep_count !== exp_count) begin
         errors++; $display("[TB] FAIL ignore_done got done=%b count=%0d expected 1/%0d", sweep_done, sweep_count, exp_count);
      end
      tick();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_restart got busy=%b expected 0", busy); end
      in_valid = 1'b1; in_data = a;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_data !== m_table[a]) begin errors++; $display("[TB] FAIL ignore_table idx %0d got %b expected %b", a, out_data, m_table[a]); end
      tick();
   endtask

   task automatic test_reset_mid_sweep();
      out_ready = 1'b1; in_valid = 1'b0;
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 1'b1;
      tick();
      m_table[3] = 1'b1;
      cfg_we = 1'b0;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_table   = 8'hC5;
      m_table_w = 16'hFFFF;
      #1;
      checks++; if (busy !== 1'b0 || sweep_done !== 1'b0 || sweep_count !== 4'd0) begin
         errors++; $display("[TB] FAIL midreset got busy=%b done=%b count=%0d expected 0/0/0", busy, sweep_done, sweep_count);
      end
      tick();
      #1;
      checks++; if (sweep_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_done got done=%b busy=%b expected 0/0", sweep_done, busy); end
      in_valid = 1'b1; in_data = 3'd3;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_data !== m_table[3]) begin errors++; $display("[TB] FAIL midreset_table got %b expected %b", out_data, m_table[3]); end
      tick();
      test_sweep($countones(m_table));
   endtask

   task automatic test_wide_sweep();
      for (int r = 0; r < 2; r++) begin
         if (r == 1) begin
            w_cfg_we = 1'b1; w_cfg_addr = 4'd7; w_cfg_data = 1'b0;
            tick();
            m_table_w[7] = 1'b0;
            w_cfg_we = 1'b0;
         end
         w_sweep_start = 1'b1;
         tick();
         w_sweep_start = 1'b0;
         for (int c = 1; c <= 16; c++) begin
            #1;
            checks++; if (w_busy !== 1'b1 || w_sweep_done !== 1'b0) begin
               errors++; $display("[TB] FAIL wide_busy run %0d cycle %0d got busy=%b done=%b expected 1/0", r, c, w_busy, w_sweep_done);
            end
            tick();
         end
         #1;
         checks++; if (w_busy !== 1'b0 || w_sweep_done !== 1'b1 || w_sweep_count !== 5'($countones(m_table_w))) begin
            errors++; $display("[TB] FAIL wide_done run %0d got busy=%b done=%b count=%0d expected 0/1/%0d", r, w_busy, w_sweep_done, w_sweep_count, $countones(m_table_w));
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sweep_start = 1'b0;
      w_cfg_we = 1'b0; w_cfg_addr = '0; w_cfg_data = 1'b0;
      w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1; w_sweep_start = 1'b0;
      test_reset();
      test_eval_default();
      test_sweep($countones(m_table));
      test_write_collision();
      test_backpressure();
      test_sweep_ignore();
      test_reset_mid_sweep();
      test_wide_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Parametrised, programmable N-input truth-table evaluator. Successor to the team's fixed 3-input gate-level truth-table block.
- The table is stored in a register, is runtime-writable, and resets to a parameter value.
- Single-input evaluations pass through a registered valid/ready stage.
- A self-sweep mode walks all 2^N_IN input combinations and reports how many minterms are 1.

Parameters:
- N_IN, 3, number of table inputs (1..8); table depth is 2^N_IN.
- DEFAULT_TABLE, 8'hC5, reset contents, 2^N_IN bits; bit i is the output for input index i. The default implements Y = A·B + ~(A+C), with index = {A,B,C}.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  table bit write strobe
- cfg_addr  in  N_IN  table index to write
- cfg_data  in  1  value written to table[cfg_addr]
- in_valid  in  1  evaluation request valid
- in_ready  out  1  evaluation request accepted when in_valid & in_ready
- in_data  in  N_IN  input vector; index = in_data, MSB is input A
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  1  table[in_data] of the accepted request
- sweep_start  in  1  request full-table sweep (single-cycle pulse)
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse when sweep_count is updated
- sweep_count  out  N_IN+1  number of 1 bits in the table at sweep time

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - table <= DEFAULT_TABLE; FSM <= IDLE.
  - out_valid=0, out_data=0, busy=0, sweep_done=0, sweep_count=0.
  - Reset mid-sweep aborts the sweep; no done pulse is generated.
- Eval path, one register stage:
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - On accept, out_data <= table[in_data] and out_valid <= 1. Latency is 1 cycle.
  - out_valid clears when out_ready=1 and there is no new accept that cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - Back-to-back throughput is 1 per cycle when out_ready=1.
- Config writes:
  - Applied at the edge only when state==IDLE; ignored (dropped) in SWEEP or DONE.
  - A write and an eval of the same index in the same cycle: the eval uses the OLD bit. The new value is visible from the next cycle.
- FSM states IDLE, SWEEP, DONE:
  - IDLE -> SWEEP: on sweep_start. idx <= 0, acc <= 0.
  - sweep_start outside IDLE is ignored.
  - A sweep_start and an eval accept in the same cycle are both honoured.
  - SWEEP: each cycle, acc += table[idx] and idx += 1. One index per cycle, 2^N_IN cycles.
  - SWEEP -> DONE: after the last index, with sweep_count <= final acc.
  - DONE -> IDLE: unconditionally after 1 cycle. sweep_done=1 only in DONE.
- Timing relative to a sweep_start sampled at edge k:
  - busy=1 in cycles k+1 .. k+2^N_IN.
  - sweep_done=1 in cycle k+2^N_IN+1; busy=0 in that cycle.
  - in_ready=0 from k+1 through the DONE cycle.
- Output hold and overflow:
  - A result already pending in the out register stays valid and may be drained during SWEEP.
  - sweep_count holds its value until the next completed sweep.
  - acc is N_IN+1 bits wide, so an all-ones table gives 2^N_IN with no overflow. idx wraps naturally and is not used after the last index.

Decomposition:
- Package lut_eval_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - function popcount_w(N_IN) = N_IN+1;
  - the DEFAULT_TABLE constant for the 3-input case.
- Natural sub-module: lut_table_reg. It holds the 2^N_IN-bit register with synchronous reset to DEFAULT_TABLE, has a bit-write port and a combinational read port, and is instantiated once for a shared eval/sweep read mux.

Test Plan:
- Reset, then eval in_data=0..7 with out_ready=1 -> out_data sequence 1,0,1,0,0,0,1,1, each valid 1 cycle after accept.
- Default-table sweep: sweep_start -> busy for 8 cycles, sweep_done pulse in the 9th, sweep_count=4, in_ready=0 throughout.
- Write cfg_addr=1 cfg_data=1 and eval in_data=1 in the same cycle -> out_data=0; eval again next cycle -> 1. A following sweep gives sweep_count=5.
- Backpressure: out_ready=0 with in_valid=1 -> in_ready=0 after the first accept, out_data held. Raise out_ready -> one transfer per cycle resumes with no data lost or duplicated.
- cfg_we and a second sweep_start issued during SWEEP -> both ignored; sweep_count unchanged by them; table unchanged after DONE.
- rst_n=0 in sweep cycle 4 -> next cycle busy=0, no sweep_done, sweep_count=0, table=8'hC5. N_IN=4 with an all-ones table -> sweep_count=16 after 16 busy cycles.
